// File: rtl/mem_stage_dm_pkg.sv
// Shared MIPS definitions: memory opcodes, default data-array depth and opcode class helpers.
package mem_stage_dm_pkg;

  localparam int DEPTH_DEF = 1024;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/mem_stage_dm_load_ext.sv
// Load lane select and sign/zero extension for lw/lh/lhu/lb/lbu.
// Latency: combinational. Backpressure: none.
// Non-load opcodes produce 0.
module mem_load_ext
  import mem_stage_dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [5:0]  opcode,
  output logic [31:0] DR_M
);

  logic [7:0]  byte_dat;
  logic [15:0] half_dat;

  always_comb begin
    byte_dat = word[{lane, 3'b000} +: 8];
    half_dat = lane[1] ? word[31:16] : word[15:0];
    case (opcode)
      OP_LW:   DR_M = word;
      OP_LH:   DR_M = {{16{half_dat[15]}}, half_dat};
      OP_LHU:  DR_M = {16'h0000, half_dat};
      OP_LB:   DR_M = {{24{byte_dat[7]}}, byte_dat};
      OP_LBU:  DR_M = {24'h000000, byte_dat};
      default: DR_M = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_dm.sv
// MIPS M-stage data memory: byte-lane stores, zero-latency extended loads, store counter.
// Latency: loads combinational, stores commit on next clk. Backpressure: none, one access per cycle.
// Misaligned or out-of-range accesses flag addr_err and are suppressed.
module mem_stage_dm
  import mem_stage_dm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC4_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  output logic [31:0] DR_M,
  output logic        addr_err,
  output logic [31:0] wr_cnt
);

  localparam int AW = $clog2(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   wr_cnt_q;
  logic [5:0]    op;
  logic          ld, st, out_rng, misaligned, commit;
  logic [AW-3:0] word_idx;
  logic [31:0]   rd_word, wdat, merged, ext_dr;
  logic [3:0]    be;
  logic          unused_ir;

  assign op        = IR_M[31:26];
  assign unused_ir = ^IR_M[25:0];
  assign ld        = is_load(op);
  assign st        = is_store(op);
  assign word_idx  = AO_M[AW-1:2];
  assign rd_word   = mem[word_idx];
  assign out_rng   = AO_M >= 32'(4 * DEPTH);

  always_comb begin
    case (op)
      OP_LW, OP_SW:         misaligned = AO_M[1:0] != 2'b00;
      OP_LH, OP_LHU, OP_SH: misaligned = AO_M[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign addr_err = (ld || st) && (out_rng || misaligned);
  assign commit   = st && !addr_err && !reset;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (op)
      OP_SW:   begin be = 4'b1111;                          wdat = RT_M; end
      OP_SH:   begin be = AO_M[1] ? 4'b1100 : 4'b0011;      wdat = {2{RT_M[15:0]}}; end
      OP_SB:   begin be = 4'b0001 << AO_M[1:0];             wdat = {4{RT_M[7:0]}}; end
      default: begin be = 4'b0000;                          wdat = 32'h0000_0000; end
    endcase
    for (int l = 0; l < 4; l++)
      merged[8*l +: 8] = be[l] ? wdat[8*l +: 8] : rd_word[8*l +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0000_0000;
      wr_cnt_q <= 32'h0000_0000;
    end else if (commit) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[word_idx][8*l +: 8] <= wdat[8*l +: 8];
      wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign wr_cnt = wr_cnt_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (commit)
      $display("@%08h: *%08h <= %08h", PC4_M - 32'd4, {AO_M[31:2], 2'b00}, merged);
  end
`endif

  mem_load_ext u_load_ext (
    .word   (rd_word),
    .lane   (AO_M[1:0]),
    .opcode (op),
    .DR_M   (ext_dr)
  );

  assign DR_M = (ld && !addr_err) ? ext_dr : 32'h0000_0000;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a byte-array reference model.
module tb_mem_stage_dm;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_M, PC4_M, AO_M, RT_M;
  logic [31:0] DR_M, wr_cnt;
  logic        addr_err;

  mem_stage_dm #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .IR_M     (IR_M),
    .PC4_M    (PC4_M),
    .AO_M     (AO_M),
    .RT_M     (RT_M),
    .DR_M     (DR_M),
    .addr_err (addr_err),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [7:0]  mem_m [4*DEPTH];
  logic [31:0] cnt_m;
  logic [31:0] pc = 32'h0040_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-addressed) ----------------
  function automatic bit m_isld(input logic [5:0] op);
    return op == 6'h23 || op == 6'h21 || op == 6'h25 || op == 6'h20 || op == 6'h24;
  endfunction
  function automatic bit m_isst(input logic [5:0] op);
    return op == 6'h2B || op == 6'h29 || op == 6'h28;
  endfunction
  function automatic int m_size(input logic [5:0] op);
    if (op == 6'h23 || op == 6'h2B) return 4;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 1;
  endfunction
  function automatic bit m_err(input logic [5:0] op, input logic [31:0] ao);
    if (!m_isld(op) && !m_isst(op)) return 1'b0;
    if (ao >= 4 * DEPTH) return 1'b1;
    return (ao % m_size(op)) != 0;
  endfunction
  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] ao);
    logic [31:0] v;
    int n;
    if (!m_isld(op) || m_err(op, ao)) return 32'h0;
    n = m_size(op);
    v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(mem_m[ao + k]) << (8 * k));
    if (op == 6'h21 && v[15]) v = v | 32'hFFFF_0000;
    if (op == 6'h20 && v[7])  v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  // Compare process: checks outputs mid-cycle, then advances the model to post-edge state.
  always @(negedge clk) begin
    logic [5:0] op;
    op = IR_M[31:26];
    if (chk_en && !reset) begin
      check("addr_err", {31'b0, addr_err}, {31'b0, m_err(op, AO_M)});
      check("DR_M", DR_M, m_load(op, AO_M));
      check("wr_cnt", wr_cnt, cnt_m);
    end
    if (reset) begin
      for (int i = 0; i < 4 * DEPTH; i++) mem_m[i] = 8'h00;
      cnt_m = 32'h0;
    end else if (m_isst(op) && !m_err(op, AO_M)) begin
      for (int k = 0; k < m_size(op); k++) mem_m[AO_M + k] = RT_M[8*k +: 8];
      cnt_m = cnt_m + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rt,
                       input logic rst);
    @(posedge clk);
    #1;
    reset = rst;
    IR_M  = {op, 26'($urandom)};
    AO_M  = ao;
    RT_M  = rt;
    PC4_M = pc + 32'd4;
    pc    = pc + 32'd4;
    #1;
  endtask

  localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24;
  localparam logic [5:0] SW = 6'h2B, SH = 6'h29, SB = 6'h28;

  logic [5:0] ops [10];

  initial begin
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00, 6'h0F};
    reset = 1'b1; IR_M = 32'h0; AO_M = 32'h0; RT_M = 32'h0; PC4_M = 32'h0;
    repeat (2) @(posedge clk);
    apply(6'h00, 32'h0, 32'h0, 1'b0);
    chk_en = 1'b1;
    check("rst_wr_cnt", wr_cnt, 32'h0);

    apply(LW, 32'h40, 32'h0, 1'b0);
    check("rst_lw_zero", DR_M, 32'h0);

    apply(SW, 32'h10, 32'h1234_5678, 1'b0);
    apply(LW, 32'h10, 32'h0, 1'b0);
    check("sw_lw", DR_M, 32'h1234_5678);
    check("sw_cnt", wr_cnt, 32'd1);

    apply(SB, 32'h13, 32'h0000_00AB, 1'b0);
    apply(LB, 32'h13, 32'h0, 1'b0);
    check("lb_sext", DR_M, 32'hFFFF_FFAB);
    apply(LBU, 32'h13, 32'h0, 1'b0);
    check("lbu_zext", DR_M, 32'h0000_00AB);
    apply(LW, 32'h10, 32'h0, 1'b0);
    check("sb_merge", DR_M, 32'hAB34_5678);

    apply(SW, 32'h20, 32'h1122_3344, 1'b0);
    apply(SH, 32'h22, 32'h0000_8001, 1'b0);
    apply(LH, 32'h22, 32'h0, 1'b0);
    check("lh_sext", DR_M, 32'hFFFF_8001);
    apply(LHU, 32'h22, 32'h0, 1'b0);
    check("lhu_zext", DR_M, 32'h0000_8001);
    apply(LW, 32'h20, 32'h0, 1'b0);
    check("sh_lanes01", DR_M, 32'h8001_3344);

    apply(SW, 32'h11, 32'hDEAD_BEEF, 1'b0);
    check("err_sw_mis", {31'b0, addr_err}, 32'd1);
    apply(LH, 32'h13, 32'h0, 1'b0);
    check("err_lh_mis", {31'b0, addr_err}, 32'd1);
    check("err_lh_dr", DR_M, 32'h0);
    apply(SW, 32'h1000, 32'hDEAD_BEEF, 1'b0);
    check("err_sw_rng", {31'b0, addr_err}, 32'd1);
    apply(LW, 32'h10, 32'h0, 1'b0);
    check("err_nowrite", DR_M, 32'hAB34_5678);
    check("err_cnt", wr_cnt, 32'd4);

    apply(SW, 32'h40, 32'hFFFF_FFFF, 1'b0);
    apply(LW, 32'h40, 32'h0, 1'b0);
    check("fill_40", DR_M, 32'hFFFF_FFFF);
    apply(SW, 32'h40, 32'hFFFF_FFFF, 1'b1);
    apply(LW, 32'h40, 32'h0, 1'b0);
    check("rst_clr_40", DR_M, 32'h0);
    check("rst_clr_cnt", wr_cnt, 32'h0);

    apply(SW, 32'h44, 32'h5555_AAAA, 1'b0);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    cnt_m = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    apply(LW, 32'h44, 32'h0, 1'b0);
    check("cnt_wrap", wr_cnt, 32'h0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ao;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 85)      ao = $urandom_range(0, 63);
      else if (sel < 95) ao = $urandom_range(4 * DEPTH - 8, 4 * DEPTH + 8);
      else               ao = $urandom;
      apply(ops[$urandom_range(0, 9)], ao, $urandom, ($urandom_range(0, 49) == 0));
    end

    apply(6'h00, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_dm.md
MEM_STAGE_DM -- requirements
Module: mem_stage_dm

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit words in the data array; addressable range is 0 to 4*DEPTH-1.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 Port: IR_M  input  32  instruction held in the M stage by the E/M pipeline register.
REQ-005 Port: PC4_M  input  32  PC+4 of that instruction.
REQ-006 Port: AO_M  input  32  ALU result, used as the byte effective address.
REQ-007 Port: RT_M  input  32  store data, already forwarded.
REQ-008 Port: DR_M  output  32  load result, extended per opcode, combinational.
REQ-009 Port: addr_err  output  1  access is misaligned or out of range, combinational.
REQ-010 Port: wr_cnt  output  32  count of committed stores, registered.

Function
REQ-011 The block SHALL decode IR_M[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28; every other opcode is a non-memory instruction.
REQ-012 Word index SHALL be AO_M[log2(4*DEPTH)-1:2], and byte lane SHALL be AO_M[1:0] (little-endian, lane 0 = bits 7:0).
REQ-013 addr_err SHALL be 1 for a load or store when AO_M >= 4*DEPTH, or for lw/sw with AO_M[1:0]!=0, or for lh/lhu/sh with AO_M[0]!=0; otherwise addr_err SHALL be 0.
REQ-014 A store with addr_err=0 SHALL update only its addressed lanes on the next rising clk: sw writes 4 lanes, sh writes lanes {AO_M[1],0} and +1 with RT_M[15:0], sb writes one lane with RT_M[7:0].
REQ-015 A store with addr_err=1 SHALL leave the array and wr_cnt unchanged.
REQ-016 A load with addr_err=0 SHALL drive DR_M in the same cycle with zero latency from the current array contents.
REQ-017 DR_M extension rules: lw returns the whole word; lh/lb sign-extend; lhu/lbu zero-extend.
REQ-018 DR_M SHALL be 0 for non-load instructions and for loads with addr_err=1.
REQ-019 wr_cnt SHALL increment by 1 on each committed store and wrap from 0xFFFFFFFF to 0.
REQ-020 On each committed store the block SHALL log, in simulation only: "@<PC4_M-4>: *<word address, AO_M with bits 1:0 cleared> <= <full merged word after write>", with all three values in 8-digit hex.
REQ-021 Only one instruction occupies M per cycle, so the block SHALL NOT arbitrate between a load and a store in the same cycle.
REQ-022 A load in the cycle after a store to the same word SHALL observe the stored data.

Reset
REQ-023 While reset=1 at a rising clk, every array word SHALL become 0 and wr_cnt SHALL become 0.
REQ-024 A store presented in a reset cycle SHALL be discarded and SHALL NOT be logged.
REQ-025 DR_M and addr_err SHALL need no reset because they are combinational; after reset any in-range load SHALL return 0.

Structure
REQ-026 Opcode constants and DEPTH default SHALL live in the shared MIPS definitions package used by all pipeline stages.
REQ-027 Load lane selection and extension SHALL be a sub-module named mem_load_ext (inputs: word, AO_M[1:0], opcode; output: DR_M).
REQ-028 The array SHALL be a single reg array with per-lane write enables; no vendor RAM primitive.

Verification
REQ-029 Scenario: sw RT=0x12345678 @AO=0x10, then lw @0x10 -> DR_M=0x12345678, wr_cnt=1, log "@<pc>: *00000010 <= 12345678".
REQ-030 Scenario: sb RT=0x000000AB @0x13 onto word 0x12345678, then lb @0x13 and lbu @0x13 -> word 0xAB345678, lb DR_M=0xFFFFFFAB, lbu DR_M=0x000000AB.
REQ-031 Scenario: sh RT=0x8001 @0x22, then lh @0x22 and lhu @0x22 -> lh DR_M=0xFFFF8001, lhu DR_M=0x00008001, lanes 0-1 unchanged.
REQ-032 Scenario: sw @0x11, lh @0x13, sw @0x1000 (DEPTH=1024) -> addr_err=1 each, array and wr_cnt unchanged, no log line, DR_M=0.
REQ-033 Scenario: fill word 0x40 = 0xFFFFFFFF, assert reset 1 cycle with sw @0x40 presented -> lw @0x40 returns 0, wr_cnt=0, no log line.
REQ-034 Scenario: preset wr_cnt to 0xFFFFFFFF (via forced state), commit one sw -> wr_cnt=0.
